// File: rtl/rtc_bus_arbiter_buffer.sv
// Round-robin arbiter that owns a shared bidirectional RTC data bus for a fixed
// hold window per transaction, with a guaranteed high-Z turnaround gap between owners.
module rtc_bus_arbiter_buffer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned TURN_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       wr,
    input  logic [N_REQ*WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0]       bus,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid
);

    localparam int unsigned MAX_CYC = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
    localparam int unsigned PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, TURN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [PW-1:0]      ptr, ptr_nxt;
    logic               lat_wr, lat_wr_nxt;
    logic [WIDTH-1:0]   lat_data, lat_data_nxt;
    logic               drive, drive_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic               busy_nxt, done_nxt, rvalid_nxt;
    logic [WIDTH-1:0]   rdata_nxt;
    logic               found;
    logic [PW-1:0]      win;
    int                 idx;

    // Output enable is a flop cleared by reset, so the bus releases immediately.
    assign bus = drive ? lat_data : {WIDTH{1'bz}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            lat_wr   <= 1'b0;
            lat_data <= '0;
            drive    <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            lat_wr   <= lat_wr_nxt;
            lat_data <= lat_data_nxt;
            drive    <= drive_nxt;
            grant    <= grant_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            rvalid   <= rvalid_nxt;
            rdata    <= rdata_nxt;
        end
    end

    // Next state plus the value every registered output takes in that state.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ptr_nxt      = ptr;
        lat_wr_nxt   = lat_wr;
        lat_data_nxt = lat_data;
        drive_nxt    = 1'b0;
        grant_nxt    = '0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        rvalid_nxt   = 1'b0;
        rdata_nxt    = rdata;
        found        = 1'b0;
        win          = '0;
        idx          = 0;

        // Search upward from the pointer with wrap-around.
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = (int'(ptr) + k) % int'(N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt      = ACTIVE;
                    cnt_nxt        = '0;
                    grant_nxt[win] = 1'b1;
                    busy_nxt       = 1'b1;
                    lat_wr_nxt     = wr[win];
                    lat_data_nxt   = din[int'(win)*int'(WIDTH) +: WIDTH];
                    drive_nxt      = wr[win];
                    ptr_nxt        = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
                    done_nxt       = (HOLD_CYC == 1);
                    rvalid_nxt     = (HOLD_CYC == 1) && !wr[win];
                end
            end
            ACTIVE: begin
                busy_nxt = 1'b1;
                if (cnt == CW'(HOLD_CYC - 1)) begin
                    state_nxt = TURN;
                    cnt_nxt   = '0;
                    if (!lat_wr) begin
                        rdata_nxt = bus;
                    end
                end else begin
                    cnt_nxt    = cnt + 1'b1;
                    grant_nxt  = grant;
                    drive_nxt  = lat_wr;
                    done_nxt   = (cnt_nxt == CW'(HOLD_CYC - 1));
                    rvalid_nxt = done_nxt && !lat_wr;
                end
            end
            TURN: begin
                if (cnt == CW'(TURN_CYC - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt  = cnt + 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_bus_arbiter_buffer.sv
// Randomised and directed bench for rtc_bus_arbiter_buffer against a queue-based
// transaction model; the bench drives the bus whenever the DUT must not.
module tb_rtc_bus_arbiter_buffer;

    localparam int WIDTH = 8;
    localparam int N_REQ = 3;
    localparam int HOLD  = 4;
    localparam int TURN  = 2;

    typedef struct packed {
        logic [N_REQ-1:0] grant;
        logic             busy;
        logic             done;
        logic             rvalid;
        logic             drive;
        logic             rd_end;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [N_REQ-1:0]       req, wr;
    logic [N_REQ*WIDTH-1:0] din;
    wire  [WIDTH-1:0]       bus;
    logic [N_REQ-1:0]       grant;
    logic                   busy, done, rvalid;
    logic [WIDTH-1:0]       rdata;

    logic                   ext_en;
    logic [WIDTH-1:0]       ext_data;
    logic [WIDTH-1:0]       ext_fixed;
    bit                     ext_rand;
    bit                     chk_en;

    exp_t                   q[$];
    exp_t                   cur;
    bit                     cur_idle;
    int                     m_ptr;
    logic [WIDTH-1:0]       m_rdata;

    int                     n_checks = 0;
    int                     n_fail   = 0;
    int                     cyc      = 0;
    logic [N_REQ-1:0]       prev_grant = '0;
    logic [N_REQ-1:0]       log_g[$];
    int                     log_c[$];

    assign bus = ext_en ? ext_data : {WIDTH{1'bz}};

    rtc_bus_arbiter_buffer #(
        .WIDTH(WIDTH), .N_REQ(N_REQ), .HOLD_CYC(HOLD), .TURN_CYC(TURN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .din(din), .bus(bus),
        .grant(grant), .busy(busy), .done(done), .rdata(rdata), .rvalid(rvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur      = '0;
        cur_idle = 1'b1;
        m_ptr    = 0;
        m_rdata  = '0;
    endtask

    // A grant books HOLD owned cycles then TURN released cycles.
    task automatic push_txn();
        int  w;
        bit  w_wr;
        exp_t e;
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && req[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        end
        w_wr  = wr[w];
        m_ptr = (w + 1) % N_REQ;
        for (int h = 0; h < HOLD; h++) begin
            e        = '0;
            e.grant  = N_REQ'(1 << w);
            e.busy   = 1'b1;
            e.done   = (h == HOLD - 1);
            e.rvalid = (h == HOLD - 1) && !w_wr;
            e.rd_end = (h == HOLD - 1) && !w_wr;
            e.drive  = w_wr;
            e.data   = din[w*WIDTH +: WIDTH];
            q.push_back(e);
        end
        for (int t = 0; t < TURN; t++) begin
            e      = '0;
            e.busy = 1'b1;
            q.push_back(e);
        end
    endtask

    // Advance one clock: apply the edge to the model, then set the external bus driver.
    task automatic step();
        @(posedge clk);
        #1;
        if (cur.rd_end) m_rdata = ext_data;
        if (cur_idle && req != '0) push_txn();
        if (q.size() > 0) begin
            cur      = q.pop_front();
            cur_idle = 1'b0;
        end else begin
            cur      = '0;
            cur_idle = 1'b1;
        end
        ext_en   = !cur.drive;
        ext_data = ext_rand ? WIDTH'($urandom) : ext_fixed;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", 32'(grant), 32'(cur.grant));
            check("busy", 32'(busy), 32'(cur.busy));
            check("done", 32'(done), 32'(cur.done));
            check("rvalid", 32'(rvalid), 32'(cur.rvalid));
            check("rdata", 32'(rdata), 32'(m_rdata));
            check("bus", 32'(bus), 32'(cur.drive ? cur.data : ext_data));
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        end
        if (grant != '0 && prev_grant == '0) begin
            log_g.push_back(grant);
            log_c.push_back(cyc);
        end
        prev_grant = grant;
    end

    initial begin
        int cnt_own, cnt_busy, cnt_done, done_at, cnt_rv;
        logic [N_REQ-1:0] rr_exp[4];
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        chk_en = 1'b0; ext_rand = 1'b1; ext_fixed = '0;
        reset_n = 1'b0; req = '0; wr = '0; din = '0;
        ext_en = 1'b1; ext_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        repeat (2) step();

        // Round-robin with all requesters held high.
        log_g.delete(); log_c.delete();
        req = 3'b111; wr = 3'b101; din = 24'hC3B2A1;
        repeat (26) step();
        req = '0;
        repeat (10) step();
        check("rr_count_ge4", 32'(log_g.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < log_g.size()) check("rr_order", 32'(log_g[i]), 32'(rr_exp[i]));
            if (i > 0 && i < log_c.size()) check("rr_spacing", 32'(log_c[i] - log_c[i-1]), 32'd7);
        end

        // Single write by requester 1.
        req = 3'b010; wr = 3'b010; din = 24'h003C00;
        cnt_own = 0; cnt_busy = 0; cnt_done = 0; done_at = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            req = '0;
            #1;
            if (grant == 3'b010 && bus == 8'h3C) cnt_own++;
            if (busy) cnt_busy++;
            if (done) begin cnt_done++; done_at = i; end
        end
        check("wr_owned_cycles", 32'(cnt_own), 32'd4);
        check("wr_busy_cycles", 32'(cnt_busy), 32'd6);
        check("wr_done_count", 32'(cnt_done), 32'd1);
        check("wr_done_cycle", 32'(done_at), 32'd3);

        // Single read by requester 2 with the bus held at 8'h59 externally.
        ext_rand = 1'b0; ext_fixed = 8'h59;
        req = 3'b100; wr = 3'b000;
        cnt_rv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            req = '0;
            #1;
            if (rvalid && done) cnt_rv++;
        end
        ext_rand = 1'b1;
        check("rd_rvalid_count", 32'(cnt_rv), 32'd1);
        check("rd_rdata", 32'(rdata), 32'h59);

        // Write by requester 0; req dropped and din changed mid-transaction.
        req = 3'b001; wr = 3'b001; din = 24'h000011;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 1) begin req = '0; din = 24'h0000FF; end
            #1;
            if (i < 4) check("mid_bus_hold", 32'(bus), 32'h11);
            if (i == 3) check("mid_done", 32'(done), 32'd1);
        end
        check("rdata_held_over_write", 32'(rdata), 32'h59);

        // Reset asserted in the middle of a write of 8'hA5.
        req = 3'b010; wr = 3'b010; din = 24'h00A500;
        step();
        req = '0;
        step();
        #2;
        chk_en = 1'b0;
        ext_data = 8'h5A; ext_en = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_bus_released", 32'(bus), 32'h5A);
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rdata", 32'(rdata), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // Random requests, directions and data.
        for (int i = 0; i < 1000; i++) begin
            step();
            req = N_REQ'($urandom);
            wr  = N_REQ'($urandom);
            din = (N_REQ*WIDTH)'($urandom);
        end
        req = '0;
        repeat (10) step();
        #2;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_bus_arbiter_buffer.md
Name: rtc_bus_arbiter_buffer

Overview:
- Parametrised successor to the RTC data-line tri-state buffer.
- Arbitrates N_REQ requesters (default 3: main sequencer, write path, read path) onto a shared bidirectional WIDTH-bit RTC data bus.
- For a write it drives the requester's data for a fixed hold window. For a read it leaves the bus at Z and captures it.
- Guarantees a high-Z turnaround gap between owners, so no two drivers ever overlap.

Parameters:
- WIDTH, 8: data bus width in bits.
- N_REQ, 3: number of requesters.
- HOLD_CYC, 4: cycles a granted transaction owns the bus (>=1).
- TURN_CYC, 2: high-Z turnaround cycles after each transaction (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester bus request, level, bit i = requester i.
- wr  input  N_REQ  per-requester direction: 1 = drive (write), 0 = sample (read).
- din  input  N_REQ*WIDTH  requester i write data at bits [i*WIDTH +: WIDTH].
- bus  inout  WIDTH  RTC data bus; driven only during a write ACTIVE phase, else Z.
- grant  output  N_REQ  one-hot owner during ACTIVE, else 0.
- busy  output  1  high in ACTIVE and TURN.
- done  output  1  one-cycle pulse on the last ACTIVE cycle.
- rdata  output  WIDTH  captured read data, held until the next read.
- rvalid  output  1  one-cycle pulse, coincident with done, for read transactions.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low, as already decided.
- Reset values: grant=0, busy=0, done=0, rvalid=0, rdata=0, bus=Z, FSM=IDLE, round-robin pointer=0 (requester 0 has highest priority), counter=0.
- The tri-state enable is a registered signal cleared asynchronously, so bus goes Z immediately on reset assertion, including mid-write.
- FSM states: IDLE, ACTIVE, TURN.
- IDLE:
  - If any req bit is high, pick the winner by round-robin, searching from pointer upward with wrap-around.
  - Next cycle: enter ACTIVE, grant = one-hot winner.
  - At the same edge, latch wr[winner] and din[winner] into internal registers.
  - Set pointer = winner+1 modulo N_REQ.
  - If req == 0, stay in IDLE with all outputs idle.
- ACTIVE (exactly HOLD_CYC cycles, counter 0..HOLD_CYC-1):
  - Write: bus = latched data on every ACTIVE cycle.
  - Read: bus = Z. On the last ACTIVE cycle, rdata is loaded from bus at the clock edge that ends ACTIVE, and rvalid pulses in the first TURN cycle... no: rvalid and done are asserted during the last ACTIVE cycle, and rdata updates at the end of that cycle.
  - Then go to TURN.
- TURN (exactly TURN_CYC cycles): grant=0, bus=Z, busy=1. Then go to IDLE.
- Minimum spacing between back-to-back grants is HOLD_CYC + TURN_CYC + 1 cycles (one IDLE arbitration cycle).
- req, wr and din are sampled only in IDLE:
  - A req change or drop during ACTIVE/TURN does not abort or alter the transaction.
  - din changes during ACTIVE do not affect bus.
- Simultaneous requests: round-robin only. No requester is granted twice while another is continuously requesting.
- Counter width: clog2(max(HOLD_CYC, TURN_CYC)) + 1. The counter resets to 0 on every state change.
- rdata holds its value across writes and idle periods. It is only overwritten by a read completion.
- Unknown or Z values on bus during a read are captured as-is. Pull-ups are an external concern.

Test Plan (WIDTH=8, N_REQ=3, HOLD_CYC=4, TURN_CYC=2):
1. Reset: assert reset_n=0 mid-write of 8'hA5 -> bus goes Z in the same cycle; grant=0, busy=0, rdata=8'h00. After release, FSM is in IDLE.
2. Single write: req=3'b010, wr=3'b010, din[15:8]=8'h3C -> one cycle later grant=3'b010 and bus=8'h3C for exactly 4 cycles. done pulses on cycle 4. Then 2 cycles with bus=Z and busy=1, then busy=0.
3. Single read: req=3'b100, wr=0, external bus=8'h59 -> bus never driven by the DUT; done=rvalid=1 on the last ACTIVE cycle; rdata=8'h59 afterwards, held through a later write.
4. Round-robin: req=3'b111 held high -> grant order 001, 010, 100, 001. Successive grant rising edges are 7 cycles apart, with no overlap of driven bus cycles.
5. Mid-transaction change: grant requester 0 writing 8'h11, then drop req and change din to 8'hFF on the second ACTIVE cycle -> bus stays 8'h11 for all 4 cycles, and the transaction completes with done.
6. Turnaround contention check: a monitor asserts that bus is never driven during TURN or IDLE, and that grant is zero or one-hot at all times, over 1000 random req/wr cycles.
